// File: rtl/turbo_enc_ctrl_if.sv
// rtl/turbo_enc_ctrl_if.sv - block handshake and encoder-control signal bundle for turbo_enc_ctrl
interface turbo_enc_ctrl_if;
  logic        in_valid;
  logic        in_k;
  logic        in_ready;
  logic        abort;
  logic        enc_start;
  logic        enc_k;
  logic        il_rd_en;
  logic        enc1_tail;
  logic        enc2_tail;
  logic [12:0] bit_cnt;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic        busy;
  logic        blk_done;

  modport master (
    output in_valid, in_k, abort,
    input  in_ready, enc_start, enc_k, il_rd_en, enc1_tail, enc2_tail,
           bit_cnt, out_valid, out_sop, out_eop, busy, blk_done
  );

  modport slave (
    input  in_valid, in_k, abort,
    output in_ready, enc_start, enc_k, il_rd_en, enc1_tail, enc2_tail,
           bit_cnt, out_valid, out_sop, out_eop, busy, blk_done
  );
endinterface

// File: rtl/turbo_enc_ctrl.sv
// rtl/turbo_enc_ctrl.sv - turbo encoder block sequencer: start, data read, dual trellis tails, done
// Every output is a register loaded from the state being entered, so strobes align with state.
module turbo_enc_ctrl #(
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144
) (
  input  logic             clk,
  input  logic             aclr,
  turbo_enc_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, TAIL1, TAIL2, DONE} state_e;

  localparam logic [12:0] LAST_S = 13'(K_SMALL - 1);
  localparam logic [12:0] LAST_L = 13'(K_LARGE - 1);

  state_e      state_q;
  logic [12:0] bit_cnt_q;
  logic        enc_k_q;
  logic        in_ready_q;
  logic        busy_q;
  logic        enc_start_q;
  logic        il_rd_en_q;
  logic        enc1_tail_q;
  logic        enc2_tail_q;
  logic        out_valid_q;
  logic        out_sop_q;
  logic        out_eop_q;
  logic        blk_done_q;

  logic [12:0] last_bit;
  logic        accept;

  assign last_bit = enc_k_q ? LAST_L : LAST_S;
  // abort in IDLE does nothing except suppress a simultaneous acceptance
  assign accept   = bus.in_valid & in_ready_q & ~bus.abort;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      enc_k_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      enc_start_q <= 1'b0;
      il_rd_en_q  <= 1'b0;
      enc1_tail_q <= 1'b0;
      enc2_tail_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      blk_done_q  <= 1'b0;
    end else begin
      enc_start_q <= 1'b0;
      il_rd_en_q  <= 1'b0;
      enc1_tail_q <= 1'b0;
      enc2_tail_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      blk_done_q  <= 1'b0;
      if (bus.abort && state_q != IDLE) begin
        state_q    <= IDLE;
        bit_cnt_q  <= '0;
        in_ready_q <= 1'b1;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              state_q     <= START;
              enc_k_q     <= bus.in_k;
              in_ready_q  <= 1'b0;
              busy_q      <= 1'b1;
              enc_start_q <= 1'b1;
            end
          end
          START: begin
            state_q     <= DATA;
            bit_cnt_q   <= '0;
            il_rd_en_q  <= 1'b1;
            out_valid_q <= 1'b1;
            out_sop_q   <= 1'b1;
          end
          DATA: begin
            out_valid_q <= 1'b1;
            if (bit_cnt_q == last_bit) begin
              state_q     <= TAIL1;
              bit_cnt_q   <= '0;
              enc1_tail_q <= 1'b1;
            end else begin
              bit_cnt_q  <= bit_cnt_q + 13'd1;
              il_rd_en_q <= 1'b1;
            end
          end
          TAIL1: begin
            out_valid_q <= 1'b1;
            if (bit_cnt_q == 13'd2) begin
              state_q     <= TAIL2;
              bit_cnt_q   <= '0;
              enc2_tail_q <= 1'b1;
            end else begin
              bit_cnt_q   <= bit_cnt_q + 13'd1;
              enc1_tail_q <= 1'b1;
            end
          end
          TAIL2: begin
            if (bit_cnt_q == 13'd2) begin
              state_q    <= DONE;
              bit_cnt_q  <= '0;
              blk_done_q <= 1'b1;
            end else begin
              bit_cnt_q   <= bit_cnt_q + 13'd1;
              enc2_tail_q <= 1'b1;
              out_valid_q <= 1'b1;
              out_eop_q   <= (bit_cnt_q == 13'd1);
            end
          end
          DONE: begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
          default: begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.enc_start = enc_start_q;
  assign bus.enc_k     = enc_k_q;
  assign bus.il_rd_en  = il_rd_en_q;
  assign bus.enc1_tail = enc1_tail_q;
  assign bus.enc2_tail = enc2_tail_q;
  assign bus.bit_cnt   = bit_cnt_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.busy      = busy_q;
  assign bus.blk_done  = blk_done_q;

endmodule
